base_aburp_q: RTL and testbench



---
 rtl/base_aburp_q_if.sv | 25 ++
 rtl/base_aburp_q.sv | 82 ++++++++
 tb/tb_base_aburp_q.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/base_aburp_q_if.sv
// Handshake bundle for base_aburp_q: source push side, sink pop side and status.
// The queue takes the slave view; the producer/consumer environment takes master.
interface base_aburp_q_if #(
   parameter int width = 1,
   parameter int cnt_w = 3
) ();
   logic             i_v;
   logic             i_r;
   logic [width-1:0] i_d;
   logic             o_v;
   logic             o_r;
   logic [width-1:0] o_d;
   logic [cnt_w-1:0] o_cnt;
   logic             o_perr;

   modport slave (
      input  i_v, i_d, o_r,
      output i_r, o_v, o_d, o_cnt, o_perr
   );

   modport master (
      output i_v, i_d, o_r,
      input  i_r, o_v, o_d, o_cnt, o_perr
   );
endinterface

// File: rtl/base_aburp_q.sv
// Multi-entry burp (skid) queue: absorbs beats a source sends during its lat-cycle
// ready lag, with strict FIFO ordering and a sticky flag for pushes into a full queue.
module base_aburp_q #(
   parameter int width = 1,
   parameter int depth = 4,
   parameter int lat   = 1,
   parameter int cnt_w = $clog2(depth + 1)
) (
   input  logic         clk,
   input  logic         reset,
   base_aburp_q_if.slave bus
);
   localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(depth - 1);
   localparam logic [cnt_w-1:0] CNT_FULL = cnt_w'(depth);
   // Highest count at which the source may still be granted: leaves room for
   // every beat already granted during the lat+1 cycles of ready lag.
   localparam logic [cnt_w-1:0] CNT_RDY  = cnt_w'(depth - 1 - lat);

   logic [width-1:0] mem_q [depth];
   logic [PTR_W-1:0] wp_q, wp_d;
   logic [PTR_W-1:0] rp_q, rp_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;
   logic             i_r_q, i_r_d;
   logic             perr_q, perr_d;

   logic             push;
   logic             pop;
   logic             full;
   logic             push_acc;

   always_comb begin
      push     = bus.i_v;
      full     = (cnt_q == CNT_FULL);
      pop      = (cnt_q != '0) & bus.o_r;
      // A pop in the same cycle frees the slot, so push-with-pop at full is legal.
      push_acc = push & (~full | pop);

      wp_d = wp_q;
      if (push_acc) begin
         wp_d = (wp_q == PTR_LAST) ? '0 : wp_q + PTR_W'(1);
      end

      rp_d = rp_q;
      if (pop) begin
         rp_d = (rp_q == PTR_LAST) ? '0 : rp_q + PTR_W'(1);
      end

      cnt_d  = cnt_q + cnt_w'(push_acc) - cnt_w'(pop);
      i_r_d  = (cnt_d <= CNT_RDY);
      perr_d = perr_q | (push & full & ~pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q   <= '0;
         rp_q   <= '0;
         cnt_q  <= '0;
         i_r_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         i_r_q  <= i_r_d;
         perr_q <= perr_d;
      end
   end

   // Storage is deliberately not reset; o_d is only meaningful while o_v is high.
   always_ff @(posedge clk) begin
      if (!reset && push_acc) begin
         mem_q[wp_q] <= bus.i_d;
      end
   end

   assign bus.i_r    = i_r_q;
   assign bus.o_v    = (cnt_q != '0);
   assign bus.o_d    = mem_q[rp_q];
   assign bus.o_cnt  = cnt_q;
   assign bus.o_perr = perr_q;
endmodule

// File: tb/tb_base_aburp_q.sv
// Directed bench for base_aburp_q: three instances (depth/lat = 4/1, 6/2, 5/0)
// exercised one after another; inputs change and outputs are sampled at negedge.
module tb_base_aburp_q;
   logic clk = 1'b0;
   logic reset_a = 1'b1;
   logic reset_b = 1'b1;
   logic reset_c = 1'b1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   base_aburp_q_if #(.width(8), .cnt_w(3)) if_a ();
   base_aburp_q_if #(.width(8), .cnt_w(3)) if_b ();
   base_aburp_q_if #(.width(8), .cnt_w(3)) if_c ();

   base_aburp_q #(.width(8), .depth(4), .lat(1)) u_a (.clk(clk), .reset(reset_a), .bus(if_a));
   base_aburp_q #(.width(8), .depth(6), .lat(2)) u_b (.clk(clk), .reset(reset_b), .bus(if_b));
   base_aburp_q #(.width(8), .depth(5), .lat(0)) u_c (.clk(clk), .reset(reset_c), .bus(if_c));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] exp_d [4];
      logic       ir_exp_b [8];
      logic [2:0] cnt_exp_b [8];
      logic       ir_exp_q [6];
      logic       ir_exp_a [4];
      logic       h1, h2, allow, exp_ir, iv, orr;
      int         pushes;
      logic [7:0] model_q [$];
      logic [7:0] dat;

      if_a.i_v = 0; if_a.i_d = 0; if_a.o_r = 0;
      if_b.i_v = 0; if_b.i_d = 0; if_b.o_r = 0;
      if_c.i_v = 0; if_c.i_d = 0; if_c.o_r = 0;

      // ---------------- reset state ----------------
      tick(); tick();
      check("rst_a_ir",   32'(if_a.i_r), 0);
      check("rst_a_ov",   32'(if_a.o_v), 0);
      check("rst_a_cnt",  32'(if_a.o_cnt), 0);
      check("rst_a_perr", 32'(if_a.o_perr), 0);
      check("rst_b_ir",   32'(if_b.i_r), 0);
      check("rst_c_ir",   32'(if_c.i_r), 0);
      reset_a = 0; reset_b = 0; reset_c = 0;
      tick();
      check("a_ir_after_rst", 32'(if_a.i_r), 1);
      tick();

      // ---------------- stream 16 beats through A ----------------
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) begin
            check("stream_ov",  32'(if_a.o_v), 1);
            check("stream_od",  32'(if_a.o_d), 32'(k - 1));
            check("stream_cnt", 32'(if_a.o_cnt), 1);
            check("stream_ir",  32'(if_a.i_r), 1);
         end
         if_a.i_v = (k < 16);
         if_a.i_d = 8'(k);
         if_a.o_r = 1;
         tick();
      end
      check("stream_empty", 32'(if_a.o_v), 0);
      check("stream_perr",  32'(if_a.o_perr), 0);

      // ---------------- backpressure on B, lat=2, depth=6 ----------------
      ir_exp_b  = '{1, 1, 1, 1, 0, 0, 0, 0};
      cnt_exp_b = '{0, 1, 2, 3, 4, 5, 6, 6};
      check("b_ir_idle", 32'(if_b.i_r), 1);
      h1 = 1; h2 = 1; pushes = 0;
      for (int p = 0; p < 8; p++) begin
         check("bp_ir",  32'(if_b.i_r), 32'(ir_exp_b[p]));
         check("bp_cnt", 32'(if_b.o_cnt), 32'(cnt_exp_b[p]));
         allow = h2; h2 = h1; h1 = if_b.i_r;
         if_b.i_v = allow;
         if_b.i_d = 8'hA0 + 8'(pushes);
         if_b.o_r = 0;
         if (allow) pushes++;
         tick();
      end
      check("bp_pushes", 32'(pushes), 6);
      check("bp_full",   32'(if_b.o_cnt), 6);
      check("bp_perr",   32'(if_b.o_perr), 0);
      ir_exp_q = '{0, 0, 0, 1, 1, 1};
      for (int q = 0; q < 6; q++) begin
         check("drain_ov",  32'(if_b.o_v), 1);
         check("drain_od",  32'(if_b.o_d), 32'(8'hA0 + 8'(q)));
         check("drain_cnt", 32'(if_b.o_cnt), 32'(6 - q));
         check("drain_ir",  32'(if_b.i_r), 32'(ir_exp_q[q]));
         if_b.i_v = 0;
         if_b.o_r = 1;
         tick();
      end
      check("drain_empty", 32'(if_b.o_v), 0);
      check("drain_cnt0",  32'(if_b.o_cnt), 0);

      // ---------------- random traffic on C, depth=5, lat=0 ----------------
      exp_ir = 1;
      for (int n = 0; n < 2000; n++) begin
         check("rnd_ov",  32'(if_c.o_v), 32'(model_q.size() != 0));
         if (model_q.size() != 0) check("rnd_od", 32'(if_c.o_d), 32'(model_q[0]));
         check("rnd_cnt", 32'(if_c.o_cnt), 32'(model_q.size()));
         check("rnd_ir",  32'(if_c.i_r), 32'(exp_ir));
         iv  = exp_ir && ($urandom_range(0, 3) != 0);
         orr = ($urandom_range(0, 2) != 0);
         dat = 8'($urandom_range(0, 255));
         if_c.i_v = iv;
         if_c.i_d = dat;
         if_c.o_r = orr;
         if (orr && model_q.size() != 0) void'(model_q.pop_front());
         if (iv) model_q.push_back(dat);
         exp_ir = (model_q.size() <= 4);
         tick();
      end
      if_c.i_v = 0; if_c.o_r = 0;
      check("rnd_perr", 32'(if_c.o_perr), 0);

      // ---------------- protocol violation on A ----------------
      ir_exp_a = '{1, 1, 1, 0};
      for (int n = 0; n < 4; n++) begin
         check("fill_ir", 32'(if_a.i_r), 32'(ir_exp_a[n]));
         if_a.i_v = 1;
         if_a.i_d = 8'h40 + 8'(n);
         if_a.o_r = 0;
         tick();
      end
      check("full_cnt", 32'(if_a.o_cnt), 4);
      check("full_ir",  32'(if_a.i_r), 0);
      if_a.i_v = 1; if_a.i_d = 8'h55;
      tick();
      check("viol_cnt",  32'(if_a.o_cnt), 4);
      check("viol_perr", 32'(if_a.o_perr), 1);
      check("viol_od",   32'(if_a.o_d), 32'h40);
      if_a.i_v = 0;
      tick();
      check("perr_sticky", 32'(if_a.o_perr), 1);
      check("pp_od", 32'(if_a.o_d), 32'h40);
      if_a.i_v = 1; if_a.i_d = 8'h66; if_a.o_r = 1;
      tick();
      check("pp_perr", 32'(if_a.o_perr), 1);
      exp_d = '{8'h41, 8'h42, 8'h43, 8'h66};
      for (int n = 0; n < 4; n++) begin
         check("pp_drain_od",  32'(if_a.o_d), 32'(exp_d[n]));
         check("pp_drain_cnt", 32'(if_a.o_cnt), 32'(4 - n));
         if_a.i_v = 0; if_a.o_r = 1;
         tick();
      end
      check("pp_empty", 32'(if_a.o_v), 0);

      // ---------------- reset mid-operation on A ----------------
      for (int n = 0; n < 3; n++) begin
         if_a.i_v = 1; if_a.i_d = 8'h90 + 8'(n); if_a.o_r = 0;
         tick();
      end
      check("mid_cnt", 32'(if_a.o_cnt), 3);
      reset_a = 1; if_a.i_v = 1; if_a.i_d = 8'hEE; if_a.o_r = 1;
      tick();
      check("mid_rst_ov",   32'(if_a.o_v), 0);
      check("mid_rst_cnt",  32'(if_a.o_cnt), 0);
      check("mid_rst_ir",   32'(if_a.i_r), 0);
      check("mid_rst_perr", 32'(if_a.o_perr), 0);
      reset_a = 0; if_a.i_v = 0; if_a.o_r = 0;
      tick();
      check("mid_rel_ir", 32'(if_a.i_r), 1);
      check("mid_rel_ov", 32'(if_a.o_v), 0);
      tick();
      if_a.i_v = 1; if_a.i_d = 8'h77;
      tick();
      if_a.i_v = 0;
      check("mid_new_ov",  32'(if_a.o_v), 1);
      check("mid_new_od",  32'(if_a.o_d), 32'h77);
      check("mid_new_cnt", 32'(if_a.o_cnt), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
